// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter.
// Holds the FSM state encoding, default sizing and a clog2 helper.
package reg_arb_pkg;

   localparam int unsigned DEF_N     = 4;
   localparam int unsigned DEF_WIDTH = 8;

   // Unused fourth encoding falls back to ST_IDLE in the FSM.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_ACK   = 2'd2
   } state_e;

   // Ceiling log2, minimum 1 so index vectors are never zero width.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the register write arbiter.
// master: requesters (drive req/wdata/clear_req, observe gnt/ack/busy/q).
// slave : arbiter    (observe requests, drive gnt/ack/busy/q).
interface reg_write_arbiter_if
   import reg_arb_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned WIDTH = DEF_WIDTH
);

   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] wdata;
   logic               clear_req;
   logic [N-1:0]       gnt;
   logic [N-1:0]       ack;
   logic               busy;
   logic [WIDTH-1:0]   q;

   modport master (output req, wdata, clear_req, input gnt, ack, busy, q);
   modport slave  (input req, wdata, clear_req, output gnt, ack, busy, q);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// req     : request vector
// ptr     : search start index
// valid_c : any request set
// idx_c   : first set bit at or after ptr, wrapping modulo N
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter  int unsigned N  = DEF_N,
   localparam int unsigned PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid_c,
   output logic [PW-1:0] idx_c
);

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      valid_c = |req;
      idx_c   = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         for (int b = 0; b < int'(N); b++) begin
            if ((b == (int'(ptr) + k) % int'(N)) && req[b]) idx_c = PW'(b);
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a shared clearable data register.
// clk : system clock
// clr : asynchronous active-high reset
// bus : requester bus (req, wdata, clear_req in; gnt, ack, busy, q out)
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic          clk,
   input  logic          clr,
   reg_write_arbiter_if.slave bus
);

   localparam int unsigned PW = clog2(N);

   state_e           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    gidx_q, gidx_d;
   logic [WIDTH-1:0] q_q, q_d;

   logic             pick_valid;
   logic [PW-1:0]    pick_idx;
   logic [WIDTH-1:0] wsel;
   logic [N-1:0]     gidx_oh;

   rr_pick #(.N(N)) u_pick (
      .req     (bus.req),
      .ptr     (ptr_q),
      .valid_c (pick_valid),
      .idx_c   (pick_idx)
   );

   // Write data mux and one-hot of the granted index.
   always_comb begin
      wsel    = '0;
      gidx_oh = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (gidx_q == PW'(i)) begin
            wsel       = bus.wdata[i*WIDTH +: WIDTH];
            gidx_oh[i] = 1'b1;
         end
      end
   end

   // Next-state logic; clear requests are only honoured from IDLE.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      q_d     = q_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.clear_req) begin
               q_d = '0;
            end else if (pick_valid) begin
               gidx_d  = pick_idx;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            q_d     = wsel;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            ptr_d   = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         q_q     <= q_d;
      end
   end

   // Outputs decode only registered state and gidx.
   assign bus.gnt  = (state_q == ST_WRITE || state_q == ST_ACK) ? gidx_oh : '0;
   assign bus.ack  = (state_q == ST_ACK) ? gidx_oh : '0;
   assign bus.busy = (state_q != ST_IDLE);
   assign bus.q    = q_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter and its rr_pick picker.
module tb_reg_write_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   reg_write_arbiter_if #(.N(N), .WIDTH(W)) bus ();
   reg_write_arbiter #(.N(N), .WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));

   logic [N-1:0] pk_req;
   logic [1:0]   pk_ptr;
   logic         pk_valid;
   logic [1:0]   pk_idx;
   rr_pick #(.N(N)) u_pick_ut (.req(pk_req), .ptr(pk_ptr), .valid_c(pk_valid), .idx_c(pk_idx));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int ack_idx[$];
   int ack_cyc[$];

   // Transaction-level reference: phase 0 idle, 1 granted (write pending), 2 acking.
   int         m_phase, m_ptr, m_g;
   logic [W-1:0] m_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_ptr = 0; m_g = 0; m_q = '0;
   endtask

   task automatic model_step();
      int p;
      if (clr) begin
         model_reset();
      end else begin
         case (m_phase)
            0: begin
               if (bus.clear_req) m_q = '0;
               else begin
                  p = ref_pick(bus.req, m_ptr);
                  if (p >= 0) begin m_g = p; m_phase = 1; end
               end
            end
            1: begin m_q = bus.wdata[m_g*W +: W]; m_phase = 2; end
            default: begin m_ptr = (m_g + 1) % N; m_phase = 0; end
         endcase
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [N-1:0] eg;
      eg = (m_phase != 0) ? N'(1 << m_g) : '0;
      check({tag, "_gnt"},  32'(bus.gnt),  32'(eg));
      check({tag, "_ack"},  32'(bus.ack),  (m_phase == 2) ? 32'(eg) : 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'(m_phase != 0));
      check({tag, "_q"},    32'(bus.q),    32'(m_q));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      check_outputs("cyc");
      for (int i = 0; i < N; i++) begin
         if (bus.ack[i]) begin ack_idx.push_back(i); ack_cyc.push_back(cyc); end
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 8 && m_phase != 0; k++) cycle();
      check("wait_idle", 32'(bus.busy), 32'd0);
   endtask

   task automatic clear_log();
      ack_idx.delete();
      ack_cyc.delete();
   endtask

   initial begin
      int cnt[N];
      int e;

      // Picker unit test, exhaustive over req and ptr.
      for (int r = 0; r < 16; r++) begin
         for (int p = 0; p < N; p++) begin
            pk_req = N'(r);
            pk_ptr = 2'(p);
            #1;
            e = ref_pick(pk_req, p);
            check("pick_valid", 32'(pk_valid), 32'(e >= 0));
            if (e >= 0) check("pick_idx", 32'(pk_idx), 32'(e));
         end
      end

      // Reset held with all requesters asserted.
      clr = 1'b1;
      bus.req = 4'b1111;
      bus.wdata = 32'h44332211;
      bus.clear_req = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("rst_gnt", 32'(bus.gnt), 32'd0);
         check("rst_ack", 32'(bus.ack), 32'd0);
         check("rst_q",   32'(bus.q),   32'd0);
      end

      // Release: order 0,1,2,3,0 with one ack every 3 cycles.
      clr = 1'b0;
      clear_log();
      for (int i = 0; i < 15; i++) cycle();
      check("order_cnt", 32'(ack_idx.size()), 32'd5);
      if (ack_idx.size() == 5) begin
         for (int i = 0; i < 5; i++) check("order_idx", 32'(ack_idx[i]), 32'(i % N));
         for (int i = 1; i < 5; i++) check("ack_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
      end
      bus.req = '0;
      cycle();

      // Single request from requester 2.
      bus.wdata = 32'h00A50000 | 32'($urandom_range(0, 16'hFFFF)) | 32'h12000000;
      bus.req = 4'b0100;
      cycle();
      check("r2_gnt", 32'(bus.gnt), 32'h4);
      bus.req = '0;
      cycle();
      check("r2_q",   32'(bus.q),   32'hA5);
      check("r2_ack", 32'(bus.ack), 32'h4);
      cycle();
      check("r2_ack_end", 32'(bus.ack), 32'd0);
      check("r2_idle",    32'(bus.busy), 32'd0);

      // Pointer now at 3; then wrap to 0 and back to 3.
      bus.req = 4'b1111;
      cycle();
      check("ptr3_gnt", 32'(bus.gnt), 32'h8);
      bus.req = 4'b1001;
      for (int i = 0; i < 3; i++) cycle();
      check("wrap_gnt0", 32'(bus.gnt), 32'h1);
      for (int i = 0; i < 3; i++) cycle();
      check("wrap_gnt3", 32'(bus.gnt), 32'h8);
      bus.req = '0;
      wait_idle();

      // Clear beats request in IDLE.
      bus.wdata = 32'h0000005A;
      bus.req = 4'b0001;
      cycle();
      bus.req = '0;
      cycle();
      check("q_5a", 32'(bus.q), 32'h5A);
      wait_idle();
      bus.clear_req = 1'b1;
      bus.req = 4'b0010;
      cycle();
      check("clr_q",   32'(bus.q),   32'd0);
      check("clr_gnt", 32'(bus.gnt), 32'd0);
      bus.clear_req = 1'b0;
      cycle();
      check("after_clr_gnt", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      wait_idle();

      // Clear raised during WRITE is deferred until the next IDLE.
      bus.wdata = 32'h0000003C;
      bus.req = 4'b0001;
      cycle();
      bus.clear_req = 1'b1;
      bus.req = '0;
      cycle();
      check("defer_q_wr", 32'(bus.q), 32'h3C);
      cycle();
      check("defer_q_idle", 32'(bus.q), 32'h3C);
      cycle();
      check("defer_q_clr", 32'(bus.q), 32'd0);
      bus.clear_req = 1'b0;

      // Reset pulsed during WRITE abandons the transaction.
      bus.wdata = 32'h00771100;
      bus.req = 4'b0010;
      cycle();
      bus.req = '0;
      wait_idle();
      check("pre_q", 32'(bus.q), 32'h11);
      bus.req = 4'b0100;
      cycle();
      check("midwr_gnt", 32'(bus.gnt), 32'h4);
      clr = 1'b1;
      #1;
      model_reset();
      check("async_q",    32'(bus.q),    32'd0);
      check("async_gnt",  32'(bus.gnt),  32'd0);
      check("async_busy", 32'(bus.busy), 32'd0);
      check("async_ack",  32'(bus.ack),  32'd0);
      clear_log();
      cycle();
      clr = 1'b0;
      bus.req = 4'b1111;
      for (int i = 0; i < 6; i++) cycle();
      check("restart_cnt", 32'(ack_idx.size()), 32'd2);
      if (ack_idx.size() == 2) begin
         check("restart_0", 32'(ack_idx[0]), 32'd0);
         check("restart_1", 32'(ack_idx[1]), 32'd1);
      end
      bus.req = '0;
      wait_idle();

      // Fairness over 12 continuous transactions.
      clear_log();
      bus.req = 4'b1111;
      for (int i = 0; i < 36; i++) cycle();
      for (int i = 0; i < N; i++) cnt[i] = 0;
      foreach (ack_idx[i]) cnt[ack_idx[i]]++;
      for (int i = 0; i < N; i++) check("fair_cnt", 32'(cnt[i]), 32'd3);
      bus.req = '0;
      wait_idle();

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         if (clr) begin
            clr = 1'b0;
         end else if ($urandom_range(0, 39) == 0) begin
            clr = 1'b1;
            #1;
            model_reset();
            check_outputs("rand_clr");
         end
         bus.req       = N'($urandom_range(0, 15));
         bus.wdata     = $urandom;
         bus.clear_req = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter for a shared WIDTH-bit clearable data register. Up to N requesters compete to load the register. A separate clear request zeroes it synchronously. The block sits between the lab's requester logic (switch/button decoders, counters) and the single shared register that drives the display datapath.

## Interface
- N, default 4: number of requesters (2..8).
- WIDTH, default 8: register data width.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- req  in  N  level request per requester; bit i belongs to requester i.
- wdata  in  N*WIDTH  write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
- clear_req  in  1  level request to zero q synchronously.
- gnt  out  N  one-hot grant; all zero when no transaction is active.
- ack  out  N  one-hot, one-cycle pulse marking a completed write.
- busy  out  1  high whenever the FSM is not in IDLE.
- q  out  WIDTH  shared register contents.

## Operation
- Reset (clr=1) acts immediately and clears everything: state=IDLE, ptr=0, gidx=0, q=0, gnt=0, ack=0, busy=0.
- Internal state:
  - FSM with states IDLE, WRITE, ACK.
  - ptr: clog2(N)-bit round-robin pointer.
  - gidx: registered grant index.
- IDLE:
  - If clear_req=1: q<=0 and stay in IDLE. clear_req beats req in the same cycle.
  - Else if req!=0: gidx <= first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo N. Go to WRITE.
  - Else hold.
- WRITE:
  - gnt[gidx]=1.
  - At the edge: q <= wdata slice gidx, sampled at that edge. Go to ACK.
- ACK:
  - gnt[gidx]=1 and ack[gidx]=1.
  - At the edge: ptr <= (gidx+1) mod N, with wrap from N-1 to 0. Go to IDLE.
- Once a grant is issued, the write is committed:
  - If req[gidx] drops during WRITE, the write still happens.
  - If req[gidx] drops during ACK, nothing changes.
- clear_req during WRITE or ACK is deferred. It is serviced in the next IDLE cycle only if still asserted. Requesters hold clear_req until they see q=0.
- A requester that keeps req high after its ack is re-arbitrated normally. Because the pointer advances past it, others get served first.
- No other writes to q occur: q holds its value in every cycle not listed above.
- gnt, ack and busy are decoded only from state and gidx. They have no combinational path from req or clear_req.

## Timing
- Request at edge e0 (FSM in IDLE):
  - gnt is visible in the cycle after e0.
  - q is updated at e1.
  - ack is high for the cycle after e1.
  - The FSM is back in IDLE after e2.
- Grant latency is 1 cycle. Write latency is 2 cycles. Sustained throughput is one write per 3 cycles.
- A request arriving during WRITE or ACK waits. It is first seen at the edge ending the following IDLE cycle.
- Clear latency: q=0 one edge after clear_req is sampled in IDLE.
- If clr asserts mid-transaction:
  - The write is abandoned and no ack is issued.
  - If clr asserts during WRITE before the edge, q is cleared rather than written.
- Fairness: with all N requesting continuously, each requester is granted exactly once in every N transactions.

## Structure
- Shared package reg_arb_pkg holds:
  - the state encoding constants (IDLE=2'd0, WRITE=2'd1, ACK=2'd2; the fourth encoding goes to IDLE);
  - the default N and WIDTH;
  - the clog2 helper.
- Sub-module rr_pick: purely combinational.
  - Inputs: req, ptr.
  - Outputs: valid and index of the first set bit at or after ptr, with wrap.
  - Unit-tested separately.
- The top level contains the FSM, ptr, gidx, the q register and the wdata mux.

## Test plan
- Reset with req=4'b1111 held and clr=1:
  - gnt=0, ack=0, q=0 throughout.
  - After clr falls: grant order 0,1,2,3,0, one ack every 3 cycles.
- req=4'b0100, wdata slice 2=8'hA5:
  - gnt=4'b0100 one cycle after sampling.
  - q=8'hA5 at the next edge.
  - ack=4'b0100 for exactly one cycle.
  - ptr ends at 3.
- After a grant to requester 3, req=4'b1001: next grant goes to 0 (wrap), then 3.
- clear_req=1 and req=4'b0010 together in IDLE, q=8'h5A:
  - q=0 after one edge, no grant.
  - Drop clear_req: requester 1 is granted next.
- clear_req raised during WRITE with wdata=8'h3C: q=8'h3C after the write, then q=0 one edge after the next IDLE cycle.
- clr pulsed during WRITE:
  - q=0, gnt=0, busy=0 immediately.
  - No ack is ever issued.
  - ptr=0 and arbitration restarts from requester 0.
